// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dpram_pkg;

  // Clear engine state: CLEAR zeroes one word per cycle, RUN serves user traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

  // Legal range of the read pipeline depth.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  // One byte-enable bit per byte of the data word.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dpram_core.sv
// Storage array: one byte-enabled write port, one registered read port, no array reset.
// Latency: read data appears one cycle after rd_en; write lands on the same edge.
// Backpressure: none; accepts one write and one read every cycle.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  localparam int BE_WIDTH  = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-masked write and read-before-write registered read; the caller keeps addresses in range.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dpram_param.sv
// Parametrised 1W/1R RAM with byte enables, write forwarding, range check and clear engine.
// Latency: READ_LATENCY (1 or 2) cycles from sampled read_enable to read_valid.
// Backpressure: none in RUN; while init_busy=1 every request is silently dropped.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            write_enable,
  input  logic [ADDR_WIDTH-1:0]           write_addr,
  input  logic [DATA_WIDTH-1:0]           write_data,
  input  logic [be_width(DATA_WIDTH)-1:0] write_be,
  input  logic                            read_enable,
  input  logic [ADDR_WIDTH-1:0]           read_addr,
  output logic [DATA_WIDTH-1:0]           read_data,
  output logic                            read_valid,
  input  logic                            init_req,
  output logic                            init_busy,
  output logic                            addr_err
);

  localparam int BE_W = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  generate
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("dpram_param: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("dpram_param: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  clr_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  run;
  logic                  wr_acc, rd_acc, wr_in_range, rd_in_range;

  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [BE_W-1:0]       core_wbe;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  s1_vld, s1_zero, s1_byp;
  logic [DATA_WIDTH-1:0] s1_wdata, s1_data;
  logic [BE_W-1:0]       s1_wbe;

  assign run         = (state == RUN);
  assign init_busy   = (state == CLEAR);
  assign wr_in_range = {1'b0, write_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, read_addr} < DEPTH_EXT;
  assign wr_acc      = run && write_enable;
  assign rd_acc      = run && read_enable;

  // Clear engine: walk the pointer 0..DEPTH-1 once, then serve traffic until init_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_ADDR) state <= RUN;
          else                      clr_ptr <= clr_ptr + 1'b1;
        end
        RUN: begin
          if (init_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  // Write port mux: clear pointer owns the port in CLEAR, in-range user writes in RUN.
  always_comb begin
    core_we    = 1'b0;
    core_waddr = clr_ptr;
    core_wdata = '0;
    core_wbe   = '1;
    if (!run) begin
      core_we = !rst;
    end else begin
      core_we    = wr_acc && wr_in_range;
      core_waddr = write_addr;
      core_wdata = write_data;
      core_wbe   = write_be;
    end
  end

  dpram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_core (
    .clk    (clk),
    .wr_en  (core_we),
    .wr_addr(core_waddr),
    .wr_data(core_wdata),
    .wr_be  (core_wbe),
    .rd_en  (rd_acc && rd_in_range),
    .rd_addr(read_addr),
    .rd_data(core_rdata)
  );

  // Per-read side info travels beside the core read; it only changes on an accepted read so data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_zero  <= 1'b1;
      s1_byp   <= 1'b0;
      s1_wdata <= '0;
      s1_wbe   <= '0;
    end else begin
      s1_vld <= rd_acc;
      if (rd_acc) begin
        s1_zero  <= !rd_in_range;
        s1_byp   <= (BYPASS != 0) && wr_acc && wr_in_range && (write_addr == read_addr);
        s1_wdata <= write_data;
        s1_wbe   <= write_be;
      end
    end
  end

  // Out-of-range reads return zero; a forwarded read overlays the enabled bytes of the same-edge write.
  always_comb begin
    s1_data = '0;
    if (!s1_zero) begin
      for (int i = 0; i < BE_W; i++) begin
        s1_data[i*8 +: 8] = (s1_byp && s1_wbe[i]) ? s1_wdata[i*8 +: 8] : core_rdata[i*8 +: 8];
      end
    end
  end

  // One pulse per edge that carried a bad address, whether from the read, the write or both.
  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else     addr_err <= (wr_acc && !wr_in_range) || (rd_acc && !rd_in_range);
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_vld;
      logic [DATA_WIDTH-1:0] s2_data;
      // Extra stage carrying data and valid together; data holds between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_data <= s1_data;
        end
      end
      assign read_valid = s2_vld;
      assign read_data  = s2_data;
    end else begin : g_lat1
      assign read_valid = s1_vld;
      assign read_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_param.sv
// Directed bench for dpram_param: dut a (DEPTH 16, latency 1, forwarding on) and
// dut b (DEPTH 12, latency 2, forwarding off) share one stimulus stream.
// Outputs are sampled 1 time unit after each rising edge.
module tb_dpram_param;

  logic        clk, rst;
  logic        write_enable, read_enable, init_req;
  logic [3:0]  write_addr, read_addr;
  logic [15:0] write_data;
  logic [1:0]  write_be;

  logic [15:0] a_rdata, b_rdata;
  logic        a_vld, b_vld, a_busy, b_busy, a_err, b_err;

  int checks = 0;
  int errors = 0;
  int na, nb, va, vb;

  dpram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
    .read_enable(read_enable), .read_addr(read_addr), .read_data(a_rdata), .read_valid(a_vld),
    .init_req(init_req), .init_busy(a_busy), .addr_err(a_err)
  );

  dpram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
    .read_enable(read_enable), .read_addr(read_addr), .read_data(b_rdata), .read_valid(b_vld),
    .init_req(init_req), .init_busy(b_busy), .addr_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs n cycles, recording the first cycle busy is low and counting valid strobes.
  task automatic run_clear(input int n, output int fa, output int fb, output int ca, output int cb);
    fa = 0; fb = 0; ca = 0; cb = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (!a_busy && fa == 0) fa = i;
      if (!b_busy && fb == 0) fb = i;
      if (a_vld) ca++;
      if (b_vld) cb++;
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    write_enable = 1'b1; write_addr = addr; write_data = data; write_be = be;
  endtask

  initial begin
    rst = 1'b1; write_enable = 1'b0; read_enable = 1'b0; init_req = 1'b0;
    write_addr = '0; read_addr = '0; write_data = '0; write_be = '0;

    // Reset state
    tick(); tick();
    chk("rst a busy", 16'(a_busy), 16'd1);
    chk("rst b busy", 16'(b_busy), 16'd1);
    chk("rst a vld",  16'(a_vld),  16'd0);
    chk("rst b vld",  16'(b_vld),  16'd0);
    chk("rst a data", a_rdata,     16'h0000);
    chk("rst b data", b_rdata,     16'h0000);
    chk("rst a err",  16'(a_err),  16'd0);
    chk("rst b err",  16'(b_err),  16'd0);

    // Power-up clear lasts exactly DEPTH cycles
    rst = 1'b0;
    run_clear(20, na, nb, va, vb);
    chk("init a cycles", 16'(na), 16'd16);
    chk("init b cycles", 16'(nb), 16'd12);

    // Back-to-back reads of every address return zero
    read_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_addr = 4'(i);
      tick();
      chk($sformatf("zero a vld %0d", i), 16'(a_vld), 16'd1);
      chk($sformatf("zero a data %0d", i), a_rdata, 16'h0000);
      chk($sformatf("zero b vld %0d", i), 16'(b_vld), (i > 0) ? 16'd1 : 16'd0);
      chk($sformatf("zero b data %0d", i), b_rdata, 16'h0000);
      chk($sformatf("zero b err %0d", i), 16'(b_err), (i >= 12) ? 16'd1 : 16'd0);
    end
    read_enable = 1'b0;
    tick();
    chk("zero a vld end", 16'(a_vld), 16'd0);
    chk("zero b vld end", 16'(b_vld), 16'd1);

    // Byte enables: BEEF then 1234 low byte only -> BE34
    wr(4'd5, 16'hBEEF, 2'b11); tick();
    wr(4'd5, 16'h1234, 2'b01); tick();
    write_enable = 1'b0; read_enable = 1'b1; read_addr = 4'd5; tick();
    read_enable = 1'b0;
    chk("be a vld",  16'(a_vld), 16'd1);
    chk("be a data", a_rdata,    16'hBE34);
    chk("be b vld early", 16'(b_vld), 16'd0);
    tick();
    chk("be b vld",  16'(b_vld), 16'd1);
    chk("be b data", b_rdata,    16'hBE34);
    chk("be a vld off", 16'(a_vld), 16'd0);
    chk("be a hold", a_rdata,    16'hBE34);

    // Same-edge read/write: forwarding vs old data, including partial byte enables
    wr(4'd7, 16'h5555, 2'b11); tick();
    wr(4'd7, 16'hAAAA, 2'b11); read_enable = 1'b1; read_addr = 4'd7; tick();
    chk("byp a full", a_rdata, 16'hAAAA);
    wr(4'd7, 16'h1200, 2'b10); tick();
    chk("byp a part", a_rdata, 16'h12AA);
    chk("byp b old1", b_rdata, 16'h5555);
    write_enable = 1'b0; tick();
    chk("byp a mem",  a_rdata, 16'h12AA);
    chk("byp b old2", b_rdata, 16'hAAAA);
    read_enable = 1'b0; tick();
    chk("byp b mem",  b_rdata, 16'h12AA);
    chk("byp b vld",  16'(b_vld), 16'd1);

    // Out-of-range on dut b (addresses 12..15); in range on dut a
    wr(4'd14, 16'h7777, 2'b11); tick();
    chk("oob wr b err", 16'(b_err), 16'd1);
    chk("oob wr a err", 16'(a_err), 16'd0);
    write_enable = 1'b0; read_enable = 1'b1; read_addr = 4'd14; tick();
    read_enable = 1'b0;
    chk("oob rd b err", 16'(b_err), 16'd1);
    chk("oob rd a data", a_rdata, 16'h7777);
    tick();
    chk("oob rd b err off", 16'(b_err), 16'd0);
    chk("oob rd b vld", 16'(b_vld), 16'd1);
    chk("oob rd b data", b_rdata, 16'h0000);
    read_enable = 1'b1; read_addr = 4'd2; tick();
    read_enable = 1'b0;
    chk("alias a data", a_rdata, 16'h0000);
    tick();
    chk("alias b data", b_rdata, 16'h0000);
    wr(4'd13, 16'h1313, 2'b11); read_enable = 1'b1; read_addr = 4'd13; tick();
    write_enable = 1'b0; read_enable = 1'b0;
    chk("oob both b err", 16'(b_err), 16'd1);
    chk("oob both a data", a_rdata, 16'h1313);
    tick();
    chk("oob both b err off", 16'(b_err), 16'd0);
    chk("oob both b vld", 16'(b_vld), 16'd1);
    chk("oob both b data", b_rdata, 16'h0000);

    // Fill with FFFF, request a clear, read during it
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 16'hFFFF, 2'b11); tick();
    end
    write_enable = 1'b0; init_req = 1'b1; tick();
    init_req = 1'b0;
    chk("clr a busy", 16'(a_busy), 16'd1);
    chk("clr b busy", 16'(b_busy), 16'd1);
    read_enable = 1'b1; read_addr = 4'd0;
    run_clear(16, na, nb, va, vb);
    read_enable = 1'b0;
    chk("clr a cycles", 16'(na), 16'd16);
    chk("clr b cycles", 16'(nb), 16'd12);
    chk("clr a vld count", 16'(va), 16'd0);
    chk("clr b vld count", 16'(vb), 16'd3);
    tick();
    read_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_addr = 4'(i);
      tick();
      chk($sformatf("clr a data %0d", i), a_rdata, 16'h0000);
      chk($sformatf("clr b data %0d", i), b_rdata, 16'h0000);
    end
    read_enable = 1'b0;
    tick(); tick();

    // Reset at clear pointer 8 restarts the full clear
    init_req = 1'b1; tick();
    init_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    run_clear(20, na, nb, va, vb);
    chk("mid rst a cycles", 16'(na), 16'd16);
    chk("mid rst b cycles", 16'(nb), 16'd12);

    // Reset with two reads in flight in dut b
    read_enable = 1'b1; read_addr = 4'd5; tick();
    tick();
    chk("fly b vld", 16'(b_vld), 16'd1);
    chk("fly a vld", 16'(a_vld), 16'd1);
    rst = 1'b1; read_enable = 1'b0; tick();
    chk("fly rst a vld", 16'(a_vld), 16'd0);
    chk("fly rst b vld", 16'(b_vld), 16'd0);
    chk("fly rst b data", b_rdata, 16'h0000);
    rst = 1'b0;
    run_clear(20, na, nb, va, vb);
    chk("fly a stale", 16'(va), 16'd0);
    chk("fly b stale", 16'(vb), 16'd0);
    chk("fly a cycles", 16'(na), 16'd16);
    chk("fly b cycles", 16'(nb), 16'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
